// File: rtl/anneal_run_sequencer.sv
// Steps a 16-entry anneal schedule, requests one downstream sample per run, and
// repeats for a latched run count, with an optional rerun batch started from DONE.
module anneal_run_sequencer #(
  parameter int SAMPLE_TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_run,
  input  logic         i_rerun,
  input  logic [7:0]   i_run_time_interval,
  input  logic [7:0]   i_total_run_count,
  input  logic [7:0]   i_total_rerun_count,
  input  logic [127:0] i_anneal_sch,
  input  logic         i_fifo_full,
  input  logic         i_sample_ack,
  output logic [7:0]   o_anneal_level,
  output logic [3:0]   o_anneal_step,
  output logic         o_running,
  output logic         o_sampling,
  output logic         o_sample_req,
  output logic         o_run_done,
  output logic [7:0]   o_runs_completed,
  output logic         o_error
);

  localparam int TW = $clog2(SAMPLE_TIMEOUT + 2);
  localparam logic [TW-1:0] TO_LIM = TW'(SAMPLE_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ANNEAL = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Step k lives in the k-th byte counted from the MSB end.
  function automatic logic [7:0] sch_byte(input logic [127:0] sch, input logic [3:0] step);
    return sch[{~step, 3'b000} +: 8];
  endfunction

  state_t         state_q, state_d;
  logic           run_q, run_d, rerun_q, rerun_d, armed_q, armed_d;
  logic [7:0]     remaining_q, remaining_d;
  logic [7:0]     interval_q, interval_d;
  logic [127:0]   sch_q, sch_d;
  logic [3:0]     step_q, step_d;
  logic [7:0]     dwell_q, dwell_d;
  logic [TW-1:0]  to_q, to_d, to_nxt;
  logic [7:0]     level_q, level_d;
  logic [3:0]     step_out_q, step_out_d;
  logic           running_q, running_d;
  logic           sampling_q, sampling_d;
  logic           done_q, done_d;
  logic [7:0]     completed_q, completed_d;
  logic           error_q, error_d;
  logic           run_rise, rerun_rise, handshake;
  logic [7:0]     dwell_lim;

  assign o_sample_req = sampling_q & ~i_fifo_full;

  // Next-state and next-output computation for the run sequencer.
  always_comb begin
    state_d     = state_q;
    run_d       = i_run;
    rerun_d     = i_rerun;
    armed_d     = 1'b1;
    remaining_d = remaining_q;
    interval_d  = interval_q;
    sch_d       = sch_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    to_d        = to_q;
    completed_d = completed_q;
    error_d     = error_q;
    done_d      = 1'b0;
    to_nxt      = to_q + 1'b1;
    // armed_q masks the first cycle so a level already high out of reset is not an edge
    run_rise    = armed_q & i_run & ~run_q;
    rerun_rise  = armed_q & i_rerun & ~rerun_q;
    handshake   = (state_q == S_SAMPLE) & o_sample_req & i_sample_ack;
    dwell_lim   = (interval_q == 8'd0) ? 8'd1 : interval_q;

    case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          remaining_d = i_total_run_count;
          interval_d  = i_run_time_interval;
          sch_d       = i_anneal_sch;
          completed_d = 8'd0;
          if (i_total_run_count == 8'd0) begin
            error_d = 1'b1;
          end else begin
            error_d = 1'b0;
            state_d = S_ANNEAL;
            step_d  = 4'd0;
            dwell_d = 8'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ANNEAL: begin
        if (!i_run) begin
          state_d = S_IDLE;
        end else if (dwell_q == dwell_lim - 8'd1) begin
          dwell_d = 8'd0;
          if (step_q == 4'd15) begin
            state_d = S_SAMPLE;
            to_d    = '0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        if (!i_run) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          done_d      = 1'b1;
          completed_d = (completed_q == 8'hFF) ? 8'hFF : completed_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q > 8'd1) begin
            state_d = S_ANNEAL;
            step_d  = 4'd0;
            dwell_d = 8'd0;
          end else begin
            state_d = S_DONE;
          end
        end else if (to_nxt >= TO_LIM) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_nxt;
        end
      end
      S_DONE: begin
        if (!i_run) begin
          state_d = S_IDLE;
        end else if (rerun_rise) begin
          remaining_d = i_total_rerun_count;
          interval_d  = i_run_time_interval;
          sch_d       = i_anneal_sch;
          completed_d = 8'd0;
          if (i_total_rerun_count == 8'd0) begin
            error_d = 1'b1;
          end else begin
            state_d = S_ANNEAL;
            step_d  = 4'd0;
            dwell_d = 8'd0;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    running_d  = (state_d == S_ANNEAL) || (state_d == S_SAMPLE);
    sampling_d = (state_d == S_SAMPLE);
    if (running_d) begin
      step_out_d = step_d;
      level_d    = sch_byte(sch_d, step_d);
    end else begin
      step_out_d = 4'd0;
      level_d    = 8'd0;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      rerun_q     <= 1'b0;
      armed_q     <= 1'b0;
      remaining_q <= 8'd0;
      interval_q  <= 8'd0;
      sch_q       <= 128'd0;
      step_q      <= 4'd0;
      dwell_q     <= 8'd0;
      to_q        <= '0;
      level_q     <= 8'd0;
      step_out_q  <= 4'd0;
      running_q   <= 1'b0;
      sampling_q  <= 1'b0;
      done_q      <= 1'b0;
      completed_q <= 8'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      rerun_q     <= rerun_d;
      armed_q     <= armed_d;
      remaining_q <= remaining_d;
      interval_q  <= interval_d;
      sch_q       <= sch_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      to_q        <= to_d;
      level_q     <= level_d;
      step_out_q  <= step_out_d;
      running_q   <= running_d;
      sampling_q  <= sampling_d;
      done_q      <= done_d;
      completed_q <= completed_d;
      error_q     <= error_d;
    end
  end

  assign o_anneal_level   = level_q;
  assign o_anneal_step    = step_out_q;
  assign o_running        = running_q;
  assign o_sampling       = sampling_q;
  assign o_run_done       = done_q;
  assign o_runs_completed = completed_q;
  assign o_error          = error_q;

endmodule

// File: tb/tb_anneal_run_sequencer.sv
// Bench for anneal_run_sequencer: directed scenarios plus random stimulus, all checked
// each cycle against a run-time arithmetic model of the sequencer.
module tb_anneal_run_sequencer;

  localparam int TIMEOUT = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_run = 1'b0, i_rerun = 1'b0;
  logic [7:0]   i_run_time_interval = 8'd0, i_total_run_count = 8'd0, i_total_rerun_count = 8'd0;
  logic [127:0] i_anneal_sch = 128'd0;
  logic         i_fifo_full = 1'b0, i_sample_ack = 1'b0;
  logic [7:0]   o_anneal_level;
  logic [3:0]   o_anneal_step;
  logic         o_running, o_sampling, o_sample_req, o_run_done, o_error;
  logic [7:0]   o_runs_completed;

  anneal_run_sequencer #(.SAMPLE_TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_rerun(i_rerun),
    .i_run_time_interval(i_run_time_interval), .i_total_run_count(i_total_run_count),
    .i_total_rerun_count(i_total_rerun_count), .i_anneal_sch(i_anneal_sch),
    .i_fifo_full(i_fifo_full), .i_sample_ack(i_sample_ack),
    .o_anneal_level(o_anneal_level), .o_anneal_step(o_anneal_step),
    .o_running(o_running), .o_sampling(o_sampling), .o_sample_req(o_sample_req),
    .o_run_done(o_run_done), .o_runs_completed(o_runs_completed), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;

  // Model: mode, cycles elapsed in the current run, and latched run parameters.
  int           m_mode, m_t, m_rem, m_comp;
  logic [7:0]   m_int;
  logic [127:0] m_sch;
  bit           m_err, m_pulse, m_prev_run, m_prev_rerun, m_armed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] m_byte(input logic [127:0] s, input int k);
    logic [127:0] tmp;
    tmp = s >> (8 * (15 - k));
    return tmp[7:0];
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_t = 0; m_rem = 0; m_comp = 0; m_int = 8'd0; m_sch = 128'd0;
    m_err = 1'b0; m_pulse = 1'b0; m_prev_run = 1'b0; m_prev_rerun = 1'b0; m_armed = 1'b0;
  endtask

  task automatic model_step();
    bit rise, rrise;
    int dw;
    if (i_rst) begin
      model_reset();
      return;
    end
    rise  = m_armed && i_run && !m_prev_run;
    rrise = m_armed && i_rerun && !m_prev_rerun;
    m_pulse = 1'b0;
    dw = (m_int == 8'd0) ? 1 : int'(m_int);
    case (m_mode)
      M_IDLE: if (rise) begin
        m_rem = i_total_run_count; m_int = i_run_time_interval; m_sch = i_anneal_sch;
        m_comp = 0;
        if (m_rem == 0) m_err = 1'b1;
        else begin m_err = 1'b0; m_mode = M_RUN; m_t = 0; end
      end
      M_RUN: begin
        if (!i_run) m_mode = M_IDLE;
        else if (m_t < 16 * dw) m_t++;
        else if (!i_fifo_full && i_sample_ack) begin
          m_pulse = 1'b1;
          if (m_comp < 255) m_comp++;
          m_rem--;
          if (m_rem > 0) m_t = 0;
          else m_mode = M_DONE;
        end else if (m_t - 16 * dw + 1 >= TIMEOUT) begin
          m_err = 1'b1; m_mode = M_IDLE;
        end else m_t++;
      end
      default: begin
        if (!i_run) m_mode = M_IDLE;
        else if (rrise) begin
          m_rem = i_total_rerun_count; m_int = i_run_time_interval; m_sch = i_anneal_sch;
          m_comp = 0;
          if (m_rem == 0) m_err = 1'b1;
          else begin m_mode = M_RUN; m_t = 0; end
        end
      end
    endcase
    m_prev_run = i_run; m_prev_rerun = i_rerun; m_armed = 1'b1;
  endtask

  task automatic compare_all();
    int dw;
    bit run, samp;
    dw   = (m_int == 8'd0) ? 1 : int'(m_int);
    run  = (m_mode == M_RUN);
    samp = run && (m_t >= 16 * dw);
    chk("running", o_running, run);
    chk("sampling", o_sampling, samp);
    chk("sample_req", o_sample_req, samp && !i_fifo_full);
    chk("run_done", o_run_done, m_pulse);
    chk("runs_completed", o_runs_completed, m_comp);
    chk("error", o_error, m_err);
    if (!samp) begin
      chk("anneal_step", o_anneal_step, run ? m_t / dw : 0);
      chk("anneal_level", o_anneal_level, run ? m_byte(m_sch, m_t / dw) : 8'd0);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    logic [127:0] ramp;
    int anneal, pulses, stall, n;
    model_reset();
    for (int k = 0; k < 16; k++) ramp[127 - 8 * k -: 8] = 8'(k);
    #12 i_rst = 1'b0;
    tick();
    chk("reset_running", o_running, 0);
    chk("reset_level", o_anneal_level, 0);
    chk("reset_completed", o_runs_completed, 0);
    chk("reset_error", o_error, 0);

    // Basic run: one run, 2-cycle dwell, ramp schedule, immediate ack
    i_total_run_count = 8'd1; i_run_time_interval = 8'd2; i_anneal_sch = ramp;
    i_sample_ack = 1'b1; i_fifo_full = 1'b0;
    tick();
    i_run = 1'b1;
    tick();
    chk("basic_start_running", o_running, 1);
    anneal = 0; pulses = 0;
    for (int c = 0; c < 80; c++) begin
      if (o_run_done) pulses++;
      if (pulses > 0 && !o_running) break;
      if (o_running && !o_sampling) begin
        chk("basic_level", o_anneal_level, anneal / 2);
        anneal++;
      end
      tick();
    end
    chk("basic_anneal_cycles", anneal, 32);
    chk("basic_pulses", pulses, 1);
    chk("basic_completed", o_runs_completed, 1);
    chk("basic_done_level", o_anneal_level, 0);
    chk("basic_done_step", o_anneal_step, 0);

    // Multi-run with a 5-cycle FIFO stall on the first sample
    i_run = 1'b0;
    tick();
    i_total_run_count = 8'd3; i_run_time_interval = 8'd0; i_fifo_full = 1'b1;
    i_run = 1'b1;
    tick();
    stall = 0; pulses = 0;
    for (int c = 0; c < 300; c++) begin
      if (stall >= 5) i_fifo_full = 1'b0;
      if (o_sampling && i_fifo_full) begin
        stall++;
        chk("stall_req_low", o_sample_req, 0);
      end
      if (o_run_done) pulses++;
      if (pulses == 3 && !o_running) break;
      tick();
    end
    chk("multi_stall_cycles", stall, 5);
    chk("multi_pulses", pulses, 3);
    chk("multi_completed", o_runs_completed, 3);
    chk("multi_error", o_error, 0);

    // Rerun batch of two from DONE
    i_total_rerun_count = 8'd2; i_run_time_interval = 8'd1; i_rerun = 1'b1;
    tick();
    chk("rerun_start", o_running, 1);
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      if (o_run_done) pulses++;
      if (pulses == 2 && !o_running) break;
      tick();
    end
    i_rerun = 1'b0;
    chk("rerun_pulses", pulses, 2);
    chk("rerun_completed", o_runs_completed, 2);

    // Abort mid-anneal at step 7
    i_run = 1'b0;
    tick();
    i_total_run_count = 8'd5; i_run_time_interval = 8'd3;
    i_run = 1'b1;
    tick();
    for (int c = 0; c < 100 && o_anneal_step != 4'd7; c++) tick();
    chk("abort_reach_step7", o_anneal_step, 7);
    i_run = 1'b0;
    tick();
    chk("abort_running", o_running, 0);
    chk("abort_no_done", o_run_done, 0);
    chk("abort_completed", o_runs_completed, 0);

    // Zero run count
    i_total_run_count = 8'd0;
    i_run = 1'b1;
    tick();
    chk("zero_error", o_error, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("zero_not_running", o_running, 0);
    end

    // Sample timeout with ack never given
    i_run = 1'b0;
    tick();
    i_total_run_count = 8'd2; i_run_time_interval = 8'd0; i_sample_ack = 1'b0;
    i_run = 1'b1;
    tick();
    for (int c = 0; c < 40 && !o_sampling; c++) tick();
    chk("timeout_reach_sample", o_sampling, 1);
    n = 0;
    while (o_sampling && n < 20) begin
      n++;
      tick();
    end
    chk("timeout_sample_cycles", n, TIMEOUT);
    chk("timeout_error", o_error, 1);
    chk("timeout_running", o_running, 0);

    // Asynchronous reset in the middle of SAMPLE; i_run stays high through it
    i_run = 1'b0;
    tick();
    i_total_run_count = 8'd1;
    i_run = 1'b1;
    tick();
    for (int c = 0; c < 40 && !o_sampling; c++) tick();
    tick();
    #2 i_rst = 1'b1;
    #1;
    chk("rst_running", o_running, 0);
    chk("rst_sampling", o_sampling, 0);
    chk("rst_req", o_sample_req, 0);
    chk("rst_level", o_anneal_level, 0);
    chk("rst_step", o_anneal_step, 0);
    chk("rst_done", o_run_done, 0);
    chk("rst_completed", o_runs_completed, 0);
    chk("rst_error", o_error, 0);
    model_reset();
    tick();
    #1 i_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_no_start", o_running, 0);
    end
    i_run = 1'b0;
    tick();
    i_run = 1'b1;
    tick();
    chk("post_rst_fresh_start", o_running, 1);

    // Random stimulus, inputs changing freely mid-run
    for (int c = 0; c < 4000; c++) begin
      if (i_run) begin
        if ($urandom_range(0, 149) == 0) i_run = 1'b0;
      end else if ($urandom_range(0, 3) == 0) i_run = 1'b1;
      if ($urandom_range(0, 19) == 0) i_rerun = ~i_rerun;
      i_sample_ack        = ($urandom_range(0, 3) != 0);
      i_fifo_full         = ($urandom_range(0, 3) == 0);
      i_total_run_count   = 8'($urandom_range(0, 3));
      i_total_rerun_count = 8'($urandom_range(0, 3));
      i_run_time_interval = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) i_anneal_sch = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/anneal_run_sequencer.md
ANNEAL_RUN_SEQUENCER -- requirements
Module: anneal_run_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_TIMEOUT, default 255, the maximum number of cycles spent in SAMPLE waiting for an acknowledge.
REQ-002 SHALL have port i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_run  in  1  RUN control level from the SPI config register.
REQ-005 SHALL have port i_rerun  in  1  RERUN control level from the SPI config register.
REQ-006 SHALL have port i_run_time_interval  in  8  dwell in cycles for each schedule step.
REQ-007 SHALL have port i_total_run_count  in  8  number of runs started by RUN.
REQ-008 SHALL have port i_total_rerun_count  in  8  number of runs started by RERUN.
REQ-009 SHALL have port i_anneal_sch  in  128  anneal schedule; step k uses bits [127-8k:120-8k].
REQ-010 SHALL have port i_fifo_full  in  1  downstream sample FIFO is full.
REQ-011 SHALL have port i_sample_ack  in  1  downstream accepts the sample request.
REQ-012 SHALL have port o_anneal_level  out  8  current schedule byte.
REQ-013 SHALL have port o_anneal_step  out  4  current step index, 0 to 15.
REQ-014 SHALL have port o_running  out  1  high in ANNEAL and SAMPLE.
REQ-015 SHALL have port o_sampling  out  1  high in SAMPLE.
REQ-016 SHALL have port o_sample_req  out  1  sample request to the downstream block.
REQ-017 SHALL have port o_run_done  out  1  one-cycle pulse per completed run.
REQ-018 SHALL have port o_runs_completed  out  8  count of completed runs since the last start.
REQ-019 SHALL have port o_error  out  1  sticky error flag.

Function
REQ-020 SHALL register i_run and i_rerun once; a start is a rising edge detected against the registered value.
REQ-021 SHALL implement the states IDLE, ANNEAL, SAMPLE and DONE, all registered.
REQ-022 SHALL leave IDLE on an i_run rising edge, taking these actions:
  - latch i_total_run_count into remaining, and i_run_time_interval and i_anneal_sch into shadow registers;
  - clear o_error and o_runs_completed;
  - if the latched count is 0, set o_error and stay in IDLE; otherwise enter ANNEAL with step 0.
REQ-023 SHALL, in ANNEAL, hold each step for max(interval,1) cycles, with o_anneal_level equal to shadow byte[step]; after step 15 completes, the next state is SAMPLE.
REQ-024 SHALL drive o_sample_req in SAMPLE = !i_fifo_full; handshake completes when o_sample_req and i_sample_ack are both high in the same cycle.
REQ-025 SHALL, on handshake completion:
  - pulse o_run_done for one cycle;
  - increment o_runs_completed, saturating at 255;
  - decrement remaining;
  - go to ANNEAL with step 0 if remaining was greater than 1, else to DONE.
REQ-026 SHALL count SAMPLE cycles without handshake, including cycles stalled by i_fifo_full; when the count reaches SAMPLE_TIMEOUT, set o_error and go to IDLE.
REQ-027 SHALL, in DONE, start a rerun on an i_rerun rising edge while i_run=1:
  - latch i_total_rerun_count;
  - re-latch the interval and schedule shadows;
  - clear o_runs_completed;
  - enter ANNEAL, or set o_error and stay in DONE if the count is 0.
REQ-028 SHALL go from DONE to IDLE when i_run=0.
REQ-029 SHALL abort to IDLE on i_run=0 in ANNEAL or SAMPLE, without o_run_done, and with o_runs_completed holding its value.
REQ-030 SHALL ignore i_rerun edges outside DONE, and ignore i_run rising edges outside IDLE.
REQ-031 SHALL not reflect input changes to the schedule, interval or counts during a run until the next start.
REQ-032 SHALL drive o_anneal_level=0 and o_anneal_step=0 in IDLE and DONE.
REQ-033 SHALL handle simultaneous events as follows: abort on i_run=0 has priority over handshake completion and over timeout; handshake completion has priority over timeout.

Reset
REQ-034 SHALL, on i_rst, asynchronously reset to IDLE with:
  - all outputs 0;
  - counters, shadows and edge-detect registers 0.
REQ-035 SHALL require a fresh i_run rising edge to start after i_rst deasserts; an i_run already high at deassertion SHALL NOT start a run.

Verification
REQ-036 SHALL verify a basic run: count=1, interval=2, schedule bytes 0x00..0x0F, ack immediately -> each level is held 2 cycles, SAMPLE is entered after 32 cycles, one o_run_done pulse, runs_completed=1, then DONE.
REQ-037 SHALL verify multi-run with a FIFO stall: count=3, interval=0, i_fifo_full held for 5 SAMPLE cycles -> o_sample_req stays low during the stall, 3 o_run_done pulses, runs_completed=3.
REQ-038 SHALL verify timeout: SAMPLE_TIMEOUT=8, ack never given -> o_error=1 after 8 SAMPLE cycles, state IDLE, o_running=0.
REQ-039 SHALL verify rerun: in DONE, rerun count=2 with an i_rerun edge -> 2 further runs, runs_completed ends at 2.
REQ-040 SHALL verify abort and reset:
  - i_run dropped mid-ANNEAL at step 7 -> IDLE next cycle, no o_run_done pulse;
  - i_rst mid-SAMPLE -> all outputs 0 immediately.
REQ-041 SHALL verify zero count: i_run edge with count=0 -> o_error=1 and o_running stays 0.
